// File: rtl/bit_rx_pkg.sv
// Shared definitions for the bit deserializer slice.
//   rx_state_t      : framing FSM states
//   MIN_PERIOD      : smallest bit period treated as locked by the recovery stage
//   CLK_LEN_DEFAULT : default width of the bit-period and phase counters
package bit_rx_pkg;

    localparam int CLK_LEN_DEFAULT = 32;
    localparam int MIN_PERIOD      = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SEARCH = 2'd1,
        DATA   = 2'd2
    } rx_state_t;

endpackage

// File: rtl/bit_phase_sampler.sv
// Re-times sampling of the raw serial line to its data edges and samples at mid-bit.
// Ports:
//   clk_300M_global   in   sole clock, rising edge
//   rst               in   synchronous active-high reset
//   signal            in   raw serial input (asynchronous)
//   bit_period        in   clock cycles per bit; below MIN_PERIOD means unlocked
//   sample_tick       out  one-cycle pulse at each mid-bit sample
//   sample_bit        out  synchronized line level, valid with sample_tick
//   loss              out  pulse when LOSS_BITS consecutive edge-free samples are reached
module bit_phase_sampler
    import bit_rx_pkg::*;
#(
    parameter int CLK_LEN   = CLK_LEN_DEFAULT,
    parameter int LOSS_BITS = 16
) (
    input  logic               clk_300M_global,
    input  logic               rst,
    input  logic               signal,
    input  logic [CLK_LEN-1:0] bit_period,
    output logic               sample_tick,
    output logic               sample_bit,
    output logic               loss
);

    localparam int RUN_W = $clog2(LOSS_BITS + 1);

    logic               sig_meta;
    logic               sig_s;
    logic               sig_d;
    logic               sig_edge;
    logic               period_ok;
    logic [CLK_LEN-1:0] phase;
    logic [RUN_W-1:0]   run_cnt;

    assign sig_edge    = sig_s ^ sig_d;
    assign period_ok   = (bit_period >= CLK_LEN'(MIN_PERIOD));
    // An edge in the sample cycle means the bit boundary moved; skip that sample.
    assign sample_tick = (phase == (bit_period >> 1)) && !sig_edge && period_ok;
    assign sample_bit  = sig_s;
    assign loss        = sample_tick && (run_cnt == RUN_W'(LOSS_BITS - 1));

    always_ff @(posedge clk_300M_global) begin
        if (rst) begin
            sig_meta <= 1'b0;
            sig_s    <= 1'b0;
            sig_d    <= 1'b0;
            phase    <= '0;
            run_cnt  <= '0;
        end else begin
            sig_meta <= signal;
            sig_s    <= sig_meta;
            sig_d    <= sig_s;

            // Edge has priority; the >= compare also recovers when the period shrinks.
            if (sig_edge) begin
                phase <= '0;
            end else if (phase >= bit_period - CLK_LEN'(1)) begin
                phase <= '0;
            end else begin
                phase <= phase + CLK_LEN'(1);
            end

            if (sig_edge) begin
                run_cnt <= '0;
            end else if (sample_tick && (run_cnt != RUN_W'(LOSS_BITS))) begin
                run_cnt <= run_cnt + RUN_W'(1);
            end
        end
    end

endmodule

// File: rtl/bit_deserializer.sv
// Serial-to-parallel receiver: finds a sync word in the sampled bit stream and
// emits the following words through a one-entry valid/ready output register.
// Ports:
//   clk_300M_global  in   sole clock, rising edge
//   rst              in   synchronous active-high reset
//   signal           in   raw serial input (asynchronous)
//   bit_period       in   clock cycles per bit from the recovery stage
//   data_out         out  received word, MSB first on the wire
//   data_valid       out  data_out holds an untransferred word
//   data_ready       in   consumer accepts when high together with data_valid
//   locked           out  high while framing words (DATA state)
//   overrun          out  sticky: a completed word was dropped, output register full
//   sample_tick      out  mid-bit sample pulse (debug)
//
// state  | meaning
// HUNT   | bit period unusable, waiting for the recovery stage to lock
// SEARCH | sampling, comparing the shift register against SYNC_WORD
// DATA   | framing WORD_LEN-bit words until edge activity is lost
module bit_deserializer
    import bit_rx_pkg::*;
#(
    parameter int                  CLK_LEN   = CLK_LEN_DEFAULT,
    parameter int                  WORD_LEN  = 8,
    parameter logic [WORD_LEN-1:0] SYNC_WORD = 8'hD5,
    parameter int                  LOSS_BITS = 16
) (
    input  logic                clk_300M_global,
    input  logic                rst,
    input  logic                signal,
    input  logic [CLK_LEN-1:0]  bit_period,
    output logic [WORD_LEN-1:0] data_out,
    output logic                data_valid,
    input  logic                data_ready,
    output logic                locked,
    output logic                overrun,
    output logic                sample_tick
);

    localparam int CNT_W = $clog2(WORD_LEN);

    rx_state_t           state;
    rx_state_t           state_nx;
    logic [WORD_LEN-1:0] sr;
    logic [WORD_LEN-1:0] sr_nx;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    bit_cnt_nx;
    logic                sample_bit;
    logic                loss;
    logic                period_ok;
    logic                word_done;
    logic                xfer;

    bit_phase_sampler #(
        .CLK_LEN   (CLK_LEN),
        .LOSS_BITS (LOSS_BITS)
    ) u_sampler (
        .clk_300M_global (clk_300M_global),
        .rst             (rst),
        .signal          (signal),
        .bit_period      (bit_period),
        .sample_tick     (sample_tick),
        .sample_bit      (sample_bit),
        .loss            (loss)
    );

    assign sr_nx     = {sr[WORD_LEN-2:0], sample_bit};
    assign period_ok = (bit_period >= CLK_LEN'(MIN_PERIOD));
    assign xfer      = data_valid && data_ready;
    assign locked    = (state == DATA);

    always_ff @(posedge clk_300M_global) begin
        if (rst) begin
            state   <= HUNT;
            bit_cnt <= '0;
            sr      <= '0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            if (sample_tick) begin
                sr <= sr_nx;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        word_done  = 1'b0;
        if (!period_ok) begin
            state_nx   = HUNT;
            bit_cnt_nx = '0;
        end else begin
            case (state)
                HUNT: begin
                    state_nx = SEARCH;
                end
                SEARCH: begin
                    if (sample_tick && (sr_nx == SYNC_WORD)) begin
                        state_nx   = DATA;
                        bit_cnt_nx = '0;
                    end
                end
                DATA: begin
                    // Loss wins over a word completing on the same sample.
                    if (loss) begin
                        state_nx   = SEARCH;
                        bit_cnt_nx = '0;
                    end else if (sample_tick) begin
                        if (bit_cnt == CNT_W'(WORD_LEN - 1)) begin
                            word_done  = 1'b1;
                            bit_cnt_nx = '0;
                        end else begin
                            bit_cnt_nx = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nx = HUNT;
                end
            endcase
        end
    end

    // A word may load into a full register only when it is draining this cycle.
    always_ff @(posedge clk_300M_global) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (word_done && (!data_valid || xfer)) begin
                data_out   <= sr_nx;
                data_valid <= 1'b1;
            end else begin
                if (word_done) begin
                    overrun <= 1'b1;
                end
                if (xfer) begin
                    data_valid <= 1'b0;
                end
            end
        end
    end

endmodule
